// File: rtl/generic_bus_clint.sv
// generic_bus_clint
//   Single-hart core-local interruptor on the generic bus. Provides a
//   free-running 64-bit mtime, a 64-bit mtimecmp and a 1-bit msip, all
//   memory-mapped with one wait state.
// Ports
//   CLK, nRST              clock, synchronous active-low reset
//   ren, wen               read / write request from the bus master
//   addr, wdata, byte_en   byte address, write data, byte lane enables
//   rdata, busy, error     read data, low-for-one-cycle completion, access fault
//   mtime                  current timer value
//   timer_int(_clear)      timer interrupt level and its falling-edge pulse
//   soft_int(_clear)       software interrupt level (msip) and its falling-edge pulse
module generic_bus_clint #(
  parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
  parameter int unsigned TIMER_PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        error,
  output logic [63:0] mtime,
  output logic        timer_int,
  output logic        timer_int_clear,
  output logic        soft_int,
  output logic        soft_int_clear
);

  localparam int unsigned   PW      = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TIMER_PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } sel_t;

  state_t        state;
  sel_t          req_sel;
  sel_t          sel_q;
  logic          req_err;
  logic [31:0]   req_rd;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          wr_q;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic [31:0]   mask;
  logic          commit;
  logic [63:0]   mtime_next;
  logic [63:0]   cmp_next;
  logic          msip_next;
  logic          ge;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [31:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  assign busy     = (state != RESP);
  assign soft_int = msip;

  // Address decode and read mux for the request being presented in IDLE.
  always_comb begin
    req_sel = SEL_NONE;
    req_rd  = '0;
    case (addr[15:0])
      16'h0000: req_sel = SEL_MSIP;
      16'h4000: req_sel = SEL_CMP_LO;
      16'h4004: req_sel = SEL_CMP_HI;
      16'hBFF8: req_sel = SEL_TIME_LO;
      16'hBFFC: req_sel = SEL_TIME_HI;
      default:  req_sel = SEL_NONE;
    endcase
    req_err = (addr[31:16] != BASE_ADDR[31:16]) || (req_sel == SEL_NONE) ||
              (addr[1:0] != 2'b00) || (ren && wen);
    case (req_sel)
      SEL_MSIP:    req_rd = {31'b0, msip};
      SEL_CMP_LO:  req_rd = mtimecmp[31:0];
      SEL_CMP_HI:  req_rd = mtimecmp[63:32];
      SEL_TIME_LO: req_rd = mtime[31:0];
      SEL_TIME_HI: req_rd = mtime[63:32];
      default:     req_rd = '0;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be_q[i]}};
    end
  end

  // A write with no lanes enabled is treated as no commit at all, so it
  // cannot steal an mtime increment either.
  assign commit = (state == RESP) && (ren || wen) && wr_q && !error && (be_q != 4'b0000);

  // A committed mtime write replaces the written word and freezes the
  // other word for that cycle instead of incrementing.
  always_comb begin
    tick       = (pcnt == PS_LAST);
    mtime_next = tick ? mtime + 64'd1 : mtime;
    if (commit && sel_q == SEL_TIME_LO) begin
      mtime_next = {mtime[63:32], merge(mtime[31:0], wdata_q, mask)};
    end
    if (commit && sel_q == SEL_TIME_HI) begin
      mtime_next = {merge(mtime[63:32], wdata_q, mask), mtime[31:0]};
    end
    cmp_next = mtimecmp;
    if (commit && sel_q == SEL_CMP_LO) begin
      cmp_next[31:0] = merge(mtimecmp[31:0], wdata_q, mask);
    end
    if (commit && sel_q == SEL_CMP_HI) begin
      cmp_next[63:32] = merge(mtimecmp[63:32], wdata_q, mask);
    end
    msip_next = msip;
    if (commit && sel_q == SEL_MSIP && be_q[0]) begin
      msip_next = wdata_q[0];
    end
    ge = (mtime >= mtimecmp);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state           <= IDLE;
      sel_q           <= SEL_NONE;
      wdata_q         <= '0;
      be_q            <= '0;
      wr_q            <= 1'b0;
      rdata           <= '0;
      error           <= 1'b0;
      pcnt            <= '0;
      mtime           <= '0;
      mtimecmp        <= '1;
      msip            <= 1'b0;
      timer_int       <= 1'b0;
      timer_int_clear <= 1'b0;
      soft_int_clear  <= 1'b0;
    end else begin
      pcnt            <= tick ? '0 : pcnt + PW'(1);
      mtime           <= mtime_next;
      mtimecmp        <= cmp_next;
      msip            <= msip_next;
      timer_int       <= ge;
      // Pulses coincide with the first cycle the level reads low.
      timer_int_clear <= timer_int & ~ge;
      soft_int_clear  <= msip & ~msip_next;
      case (state)
        IDLE: begin
          if (ren || wen) begin
            state   <= RESP;
            sel_q   <= req_sel;
            wdata_q <= wdata;
            be_q    <= byte_en;
            wr_q    <= wen & ~ren;
            error   <= req_err;
            rdata   <= req_err ? '0 : req_rd;
          end
        end
        RESP: begin
          state <= IDLE;
          rdata <= '0;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_bus_clint.sv
// tb_generic_bus_clint
//   Self-checking bench for generic_bus_clint: a register-access vector table
//   plus directed sequences for reset, timer compare, msip edges, mtime carry
//   (prescale 1 and 4), held requests and reset during a response.
module tb_generic_bus_clint;

  localparam logic [31:0] B = 32'h0200_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        b_ren, b_wen;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        tgt4;

  logic [31:0] rdata0, rdata4;
  logic        busy0, busy4, error0, error4;
  logic [63:0] mtime0, mtime4;
  logic        ti0, ti4, tic0, tic4, si0, si4, sic0, sic4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] rd;
  logic        er;
  logic [63:0] snap;

  always #5 CLK = ~CLK;

  generic_bus_clint #(.BASE_ADDR(B), .TIMER_PRESCALE(1)) u0 (
    .CLK(CLK), .nRST(nRST), .ren(b_ren & ~tgt4), .wen(b_wen & ~tgt4),
    .addr(b_addr), .wdata(b_wdata), .byte_en(b_be),
    .rdata(rdata0), .busy(busy0), .error(error0), .mtime(mtime0),
    .timer_int(ti0), .timer_int_clear(tic0), .soft_int(si0), .soft_int_clear(sic0)
  );

  generic_bus_clint #(.BASE_ADDR(B), .TIMER_PRESCALE(4)) u4 (
    .CLK(CLK), .nRST(nRST), .ren(b_ren & tgt4), .wen(b_wen & tgt4),
    .addr(b_addr), .wdata(b_wdata), .byte_en(b_be),
    .rdata(rdata4), .busy(busy4), .error(error4), .mtime(mtime4),
    .timer_int(ti4), .timer_int_clear(tic4), .soft_int(si4), .soft_int_clear(sic4)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_err);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.be = be;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete bus access; returns in the cycle after the commit edge.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    b_ren = r; b_wen = w; b_addr = a; b_wdata = d; b_be = be;
    snap = tgt4 ? mtime4 : mtime0;
    @(posedge CLK); #1;
    chk("busy_resp", {63'b0, (tgt4 ? busy4 : busy0)}, 64'd0);
    rd = tgt4 ? rdata4 : rdata0;
    er = tgt4 ? error4 : error0;
    @(posedge CLK); #1;
    b_ren = 1'b0; b_wen = 1'b0;
  endtask

  task automatic carry_test(input logic four);
    int unsigned k;
    tgt4 = four;
    access(1'b0, 1'b1, B + 32'hBFFC, 32'h0000_0007, 4'hF);
    access(1'b0, 1'b1, B + 32'hBFF8, 32'hFFFF_0000, 4'hF);
    access(1'b0, 1'b1, B + 32'hBFF8, 32'hFFFF_FFFF, 4'b0011);
    chk("carry_merge", four ? mtime4 : mtime0, 64'h0000_0007_FFFF_FFFF);
    if (!four) begin
      @(posedge CLK); #1;
      chk("carry_wrap", mtime0, 64'h0000_0008_0000_0000);
    end else begin
      k = 9;
      for (int i = 1; i <= 8; i++) begin
        @(posedge CLK); #1;
        if (mtime4 != 64'h0000_0007_FFFF_FFFF) begin
          k = i;
          break;
        end
      end
      chk("p4_carry", mtime4, 64'h0000_0008_0000_0000);
      chk("p4_carry_wait", {63'b0, (k <= 4)}, 64'd1);
      repeat (3) begin
        @(posedge CLK); #1;
        chk("p4_hold", mtime4, 64'h0000_0008_0000_0000);
      end
      @(posedge CLK); #1;
      chk("p4_next", mtime4, 64'h0000_0008_0000_0001);
    end
    tgt4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    nRST = 1'b0; b_ren = 1'b0; b_wen = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    tgt4 = 1'b0;

    vecs[0]  = mk(1, 0, B + 32'h4000, 32'h0,         4'hF, 1, 32'hFFFF_FFFF, 0);
    vecs[1]  = mk(1, 0, B + 32'h4004, 32'h0,         4'hF, 1, 32'hFFFF_FFFF, 0);
    vecs[2]  = mk(1, 0, B + 32'h0000, 32'h0,         4'hF, 1, 32'h0,         0);
    vecs[3]  = mk(0, 1, B + 32'h4000, 32'h1234_5678, 4'hF, 0, 32'h0,         0);
    vecs[4]  = mk(1, 0, B + 32'h4000, 32'h0,         4'hF, 1, 32'h1234_5678, 0);
    vecs[5]  = mk(0, 1, B + 32'h4000, 32'hAABB_CCDD, 4'b0101, 0, 32'h0,      0);
    vecs[6]  = mk(1, 0, B + 32'h4000, 32'h0,         4'hF, 1, 32'h12BB_56DD, 0);
    vecs[7]  = mk(0, 1, B + 32'h4000, 32'h0,         4'h0, 0, 32'h0,         0);
    vecs[8]  = mk(1, 0, B + 32'h4000, 32'h0,         4'hF, 1, 32'h12BB_56DD, 0);
    vecs[9]  = mk(1, 0, B + 32'h0008, 32'h0,         4'hF, 1, 32'h0,         1);
    vecs[10] = mk(1, 0, B + 32'h1_0000, 32'h0,       4'hF, 1, 32'h0,         1);
    vecs[11] = mk(1, 0, B + 32'h4002, 32'h0,         4'hF, 1, 32'h0,         1);
    vecs[12] = mk(1, 1, B + 32'h4000, 32'h0,         4'hF, 1, 32'h0,         1);
    vecs[13] = mk(0, 1, B + 32'h0008, 32'hFFFF_FFFF, 4'hF, 1, 32'h0,         1);
    vecs[14] = mk(0, 1, 32'h0201_0000, 32'h1,        4'hF, 1, 32'h0,         1);
    vecs[15] = mk(0, 1, B + 32'h4001, 32'h0,         4'hF, 1, 32'h0,         1);
    vecs[16] = mk(1, 0, B + 32'h4000, 32'h0,         4'hF, 1, 32'h12BB_56DD, 0);
    vecs[17] = mk(1, 0, B + 32'h0000, 32'h0,         4'hF, 1, 32'h0,         0);
    vecs[18] = mk(0, 1, B + 32'h0000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         0);
    vecs[19] = mk(1, 0, B + 32'h0000, 32'h0,         4'hF, 1, 32'h1,         0);
    vecs[20] = mk(0, 1, B + 32'h0000, 32'h0,         4'hF, 0, 32'h0,         0);
    vecs[21] = mk(1, 0, B + 32'h0000, 32'h0,         4'hF, 1, 32'h0,         0);
    vecs[22] = mk(1, 0, B + 32'hBFFC, 32'h0,         4'hF, 1, 32'h0,         0);

    // Reset state and free-running count.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy",  {63'b0, busy0},  64'd1);
    chk("rst_error", {63'b0, error0}, 64'd0);
    chk("rst_rdata", {32'b0, rdata0}, 64'd0);
    chk("rst_mtime", mtime0, 64'd0);
    chk("rst_ti",    {63'b0, ti0},    64'd0);
    chk("rst_si",    {63'b0, si0},    64'd0);
    chk("rst_clr",   {62'b0, tic0, sic0}, 64'd0);
    chk("rst_p4",    {mtime4[59:0], ti4, tic4, si4, sic4}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("count5",    mtime0, 64'd5);
    chk("count5_p4", mtime4, 64'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("count8",    mtime0, 64'd8);
    chk("count8_p4", mtime4, 64'd2);

    // Register access table.
    for (int i = 0; i < 23; i++) begin
      access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), {32'b0, rd}, {32'b0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_error", i), {63'b0, er}, {63'b0, vecs[i].exp_err});
    end

    // mtime low read returns the value held in the request cycle.
    access(1'b1, 1'b0, B + 32'hBFF8, 32'h0, 4'hF);
    chk("mtime_rd", {32'b0, rd}, {32'b0, snap[31:0]});
    chk("mtime_rd_err", {63'b0, er}, 64'd0);

    // Timer compare at 20.
    access(1'b0, 1'b1, B + 32'hBFF8, 32'h0, 4'hF);
    access(1'b0, 1'b1, B + 32'h4004, 32'h0, 4'hF);
    access(1'b0, 1'b1, B + 32'h4000, 32'd20, 4'hF);
    chk("ti_low_before", {63'b0, ti0}, 64'd0);
    n = 0;
    while (!ti0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ti_rise_mtime", mtime0, 64'd21);
    chk("ti_rise_clr", {63'b0, tic0}, 64'd0);
    access(1'b0, 1'b1, B + 32'h4004, 32'h1, 4'hF);
    chk("ti_hold", {62'b0, ti0, tic0}, 64'b10);
    @(posedge CLK); #1;
    chk("ti_fall", {62'b0, ti0, tic0}, 64'b01);
    @(posedge CLK); #1;
    chk("ti_clr_end", {62'b0, ti0, tic0}, 64'b00);

    // msip edges.
    access(1'b0, 1'b1, B + 32'h0000, 32'h1, 4'hF);
    chk("si_set", {62'b0, si0, sic0}, 64'b10);
    access(1'b0, 1'b1, B + 32'h0000, 32'h0, 4'hF);
    chk("si_clr", {62'b0, si0, sic0}, 64'b01);
    @(posedge CLK); #1;
    chk("si_clr_end", {62'b0, si0, sic0}, 64'b00);

    // mtime partial write and carry.
    carry_test(1'b0);
    carry_test(1'b1);

    // Request held high: accepted every other cycle only.
    @(negedge CLK);
    b_ren = 1'b1; b_addr = B; b_be = 4'hF;
    @(posedge CLK); #1; chk("held_c1", {63'b0, busy0}, 64'd0);
    @(posedge CLK); #1; chk("held_c2", {63'b0, busy0}, 64'd1);
    @(posedge CLK); #1; chk("held_c3", {63'b0, busy0}, 64'd0);
    @(posedge CLK); #1; chk("held_c4", {63'b0, busy0}, 64'd1);
    b_ren = 1'b0;

    // Reset during RESP: no commit.
    @(negedge CLK);
    b_wen = 1'b1; b_addr = B; b_wdata = 32'h1; b_be = 4'hF;
    @(posedge CLK); #1;
    chk("rr_resp", {63'b0, busy0}, 64'd0);
    nRST = 1'b0;
    @(posedge CLK); #1;
    b_wen = 1'b0;
    chk("rr_busy",  {63'b0, busy0}, 64'd1);
    chk("rr_msip",  {63'b0, si0},   64'd0);
    chk("rr_mtime", mtime0, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    access(1'b1, 1'b0, B + 32'h0000, 32'h0, 4'hF);
    chk("rr_msip_rd", {32'b0, rd}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/generic_bus_clint.md
# generic_bus_clint

Single-hart core-local interruptor that sits on the generic bus as a responder. It is the slave end of the core's generic bus master port and the source of the core's `mtime`, `timer_int`/`timer_int_clear` and `soft_int`/`soft_int_clear` inputs. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`, all memory-mapped and accessed with one wait state.

## Interface

Parameters
- `BASE_ADDR`, 32'h0200_0000: base of the 64 KiB window; only `addr[31:16]` is compared.
- `TIMER_PRESCALE`, 1: CLK cycles per `mtime` increment; must be ≥1.

Ports
- `CLK`  in  1  clock; one clock domain.
- `nRST`  in  1  reset, synchronous, active-low.
- `ren`  in  1  read request from the master.
- `wen`  in  1  write request from the master.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `byte_en`  in  4  byte lane enables; bit i selects `wdata[8i+7:8i]`.
- `rdata`  out  32  read data.
- `busy`  out  1  low for exactly the completing cycle of an access.
- `error`  out  1  access fault, valid only while `busy`=0.
- `mtime`  out  64  current timer value.
- `timer_int`  out  1  timer interrupt level.
- `timer_int_clear`  out  1  one-cycle pulse when `timer_int` falls.
- `soft_int`  out  1  software interrupt level (`msip`).
- `soft_int_clear`  out  1  one-cycle pulse when `msip` goes 1→0.

## Operation

- Register map (offset = `addr[15:0]`):
  - 0x0000: `msip`. Bit 0 is R/W. Bits 31:1 read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high, R/W.
- Access state machine, two states:
  - IDLE: if (`ren`|`wen`), capture `addr`, `wdata`, `byte_en`, and the read value of the target register, then go to RESP.
  - RESP: if the request is still asserted, commit the write at this cycle's edge, then go to IDLE. If the request has dropped, commit nothing and go to IDLE.
- `busy` = (state != RESP). The master sees completion when `busy`=0 while its request is held.
- Error cases set `error`=1 in RESP, force `rdata`=0 and suppress the write:
  - `addr[31:16]` != `BASE_ADDR[31:16]`;
  - unmapped offset;
  - `addr[1:0]` != 0;
  - `ren` and `wen` asserted together.
- Writes merge per `byte_en`. A write with `byte_en`=0 completes without error and changes nothing.
- `mtime` counter:
  - A prescale counter counts 0..`TIMER_PRESCALE`-1.
  - On wrap, `mtime` increments by 1 with full 64-bit carry; 2^64-1 wraps to 0.
  - If an `mtime` write commits in the same cycle as an increment, the written word takes the merged write value. The other word holds (no increment that cycle). The prescale counter keeps running.
- `timer_int` is registered: it equals (`mtime` >= `mtimecmp`, unsigned 64-bit) evaluated on the previous cycle's values.
- `soft_int` = `msip`.
- `*_clear` pulses are registered edge detects on `timer_int` and `msip`.

## Timing

- Reset values (nRST low at an edge):
  - state IDLE, `busy`=1, `error`=0, `rdata`=0;
  - `mtime`=0, prescale counter 0;
  - `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF;
  - `msip`=0, `timer_int`=0, `soft_int`=0, both clears 0.
- Access latency:
  - Request seen at cycle N (IDLE); `busy`=0 with `rdata`/`error` valid at cycle N+1.
  - The next request can be accepted at N+2.
- Read data is the register value at cycle N. A read of `mtime` low returns the pre-increment value of that cycle.
- A write commits at the end of cycle N+1, so the new value is visible from cycle N+2.
- After a `mtimecmp` write, `timer_int` updates at cycle N+3.
- Reset asserted in RESP: return to IDLE, no commit. Reset has priority over everything.
- Back-to-back requests: a request held high through RESP is not re-accepted. After RESP the FSM returns to IDLE and samples again.

## Test plan

- Reset: hold `nRST`=0 for 2 cycles, release -> `busy`=1, `mtime`=0, `timer_int`=0; `mtime` reads 5 at 5 cycles after release (prescale 1).
- Read `mtime` low with `ren` at cycle N -> `busy`=0 at N+1 with `rdata` = `mtime` at N, `error`=0.
- Write `mtimecmp` = {0, 20} (hi first, then lo) -> `timer_int` rises exactly when `mtime` passes 20. Then write hi = 1 -> `timer_int` falls and `timer_int_clear` pulses for 1 cycle.
- Write `msip`=1 -> `soft_int`=1 at N+2. Write 0 -> `soft_int`=0 and `soft_int_clear` single pulse.
- Read offset 0x0008, then a read at `BASE_ADDR`+0x10000, then `addr[1:0]`=2, then `ren`&`wen` -> each completes with `error`=1, `rdata`=0, no state change.
- Write `mtime` low = 32'hFFFF_FFFF with `byte_en`=4'b0011, `wdata`=32'hFFFF_FFFF on an `mtime` low of 32'hFFFF_0000 -> low = 32'hFFFF_FFFF, high unchanged. Next increment carries: low=0, high+1. Repeat with `TIMER_PRESCALE`=4 -> increments every 4 cycles.
